// File: rtl/dp_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dp_issue_arbiter
//  Purpose  : Round-robin issue arbiter with credit-limited in-flight tracking
//             and requester-tag steering of in-order datapath results.
//  Revision : 1.0  initial release
// ============================================================================
module dp_issue_arbiter #(
    parameter int NREQ         = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int IDW          = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*8-1:0]             req_warp,
    input  logic [NREQ*4-1:0]             req_op,
    input  logic [NREQ*32-1:0]            req_imm,
    output logic                          dp_in_valid,
    input  logic                          dp_in_ready,
    output logic [7:0]                    dp_warp,
    output logic [3:0]                    dp_op,
    output logic [31:0]                   dp_imm,
    input  logic                          dp_out_valid,
    output logic                          dp_out_ready,
    input  logic [7:0]                    dp_out_warp,
    input  logic [31:0]                   dp_out_data,
    output logic [NREQ-1:0]               rsp_valid,
    input  logic [NREQ-1:0]               rsp_ready,
    output logic [7:0]                    rsp_warp,
    output logic [31:0]                   rsp_data,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          tag_err
);

    localparam int              c_cw   = $clog2(MAX_INFLIGHT) + 1;
    localparam int              c_pw   = $clog2(MAX_INFLIGHT);
    localparam logic [c_cw-1:0] c_max  = c_cw'(MAX_INFLIGHT);
    localparam logic [IDW-1:0]  c_last = IDW'(NREQ - 1);

    logic [7:0]  warp_arr [NREQ];
    logic [3:0]  op_arr   [NREQ];
    logic [31:0] imm_arr  [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign warp_arr[gi] = req_warp[gi*8 +: 8];
        assign op_arr[gi]   = req_op[gi*4 +: 4];
        assign imm_arr[gi]  = req_imm[gi*32 +: 32];
    end

    logic            iss_valid_q, iss_valid_d;
    logic [7:0]      iss_warp_q,  iss_warp_d;
    logic [3:0]      iss_op_q,    iss_op_d;
    logic [31:0]     iss_imm_q,   iss_imm_d;
    logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [c_cw-1:0] inflight_q,  inflight_d;
    logic [c_pw-1:0] wr_ptr_q,    wr_ptr_d;
    logic [c_pw-1:0] rd_ptr_q,    rd_ptr_d;
    logic [IDW-1:0]  tag_mem_q [MAX_INFLIGHT];
    logic [IDW-1:0]  tag_mem_d [MAX_INFLIGHT];
    logic            tag_err_q,   tag_err_d;

    logic            any_valid;
    logic [IDW-1:0]  grant_idx;
    logic            can_issue;
    logic            grant;
    logic            fifo_nonempty;
    logic [IDW-1:0]  head;
    logic            retire;

    // Rotating search: the first index examined is the one after the last winner.
    always_comb begin
        logic [IDW-1:0] scan_idx;
        any_valid = 1'b0;
        grant_idx = '0;
        scan_idx  = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (scan_idx == c_last) ? '0 : scan_idx + 1'b1;
            if (!any_valid && req_valid[scan_idx]) begin
                any_valid = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        can_issue     = (!iss_valid_q || dp_in_ready) && (inflight_q < c_max);
        grant         = any_valid && can_issue && !rst;
        req_ready     = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end

        // FIFO occupancy tracks the credit count exactly, so it doubles as the empty flag.
        fifo_nonempty = (inflight_q != '0);
        head          = tag_mem_q[rd_ptr_q];
        rsp_valid     = '0;
        if (!rst && dp_out_valid && fifo_nonempty) begin
            rsp_valid[head] = 1'b1;
        end
        dp_out_ready  = !rst && fifo_nonempty && rsp_ready[head];
        retire        = dp_out_valid && dp_out_ready;
    end

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_warp_d  = iss_warp_q;
        iss_op_d    = iss_op_q;
        iss_imm_d   = iss_imm_q;
        rr_ptr_d    = rr_ptr_q;
        tag_mem_d   = tag_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        inflight_d  = inflight_q;
        tag_err_d   = tag_err_q || (dp_out_valid && !fifo_nonempty);

        if (grant) begin
            iss_valid_d          = 1'b1;
            iss_warp_d           = warp_arr[grant_idx];
            iss_op_d             = op_arr[grant_idx];
            iss_imm_d            = imm_arr[grant_idx];
            rr_ptr_d             = grant_idx;
            tag_mem_d[wr_ptr_q]  = grant_idx;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end else if (iss_valid_q && dp_in_ready) begin
            iss_valid_d = 1'b0;
        end

        if (retire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (grant && !retire) begin
            inflight_d = inflight_q + 1'b1;
        end else if (retire && !grant) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_warp_q  <= '0;
            iss_op_q    <= '0;
            iss_imm_q   <= '0;
            rr_ptr_q    <= c_last;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tag_err_q   <= 1'b0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                tag_mem_q[i] <= '0;
            end
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_warp_q  <= iss_warp_d;
            iss_op_q    <= iss_op_d;
            iss_imm_q   <= iss_imm_d;
            rr_ptr_q    <= rr_ptr_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tag_err_q   <= tag_err_d;
            tag_mem_q   <= tag_mem_d;
        end
    end

    assign dp_in_valid = iss_valid_q;
    assign dp_warp     = iss_warp_q;
    assign dp_op       = iss_op_q;
    assign dp_imm      = iss_imm_q;
    assign rsp_warp    = dp_out_warp;
    assign rsp_data    = dp_out_data;
    assign inflight    = inflight_q;
    assign tag_err     = tag_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_issue_arbiter
//  Purpose  : Randomized bench for dp_issue_arbiter against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dp_issue_arbiter;

    localparam int NREQ = 4;
    localparam int MAXI = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*8-1:0]  req_warp = '0;
    logic [NREQ*4-1:0]  req_op = '0;
    logic [NREQ*32-1:0] req_imm = '0;
    logic               dp_in_valid;
    logic               dp_in_ready = 1'b0;
    logic [7:0]         dp_warp;
    logic [3:0]         dp_op;
    logic [31:0]        dp_imm;
    logic               dp_out_valid = 1'b0;
    logic               dp_out_ready;
    logic [7:0]         dp_out_warp = '0;
    logic [31:0]        dp_out_data = '0;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready = '0;
    logic [7:0]         rsp_warp;
    logic [31:0]        rsp_data;
    logic [2:0]         inflight;
    logic               tag_err;

    always #5 clk = ~clk;

    dp_issue_arbiter #(.NREQ(NREQ), .MAX_INFLIGHT(MAXI), .IDW(IDW)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_warp(req_warp), .req_op(req_op), .req_imm(req_imm),
        .dp_in_valid(dp_in_valid), .dp_in_ready(dp_in_ready),
        .dp_warp(dp_warp), .dp_op(dp_op), .dp_imm(dp_imm),
        .dp_out_valid(dp_out_valid), .dp_out_ready(dp_out_ready),
        .dp_out_warp(dp_out_warp), .dp_out_data(dp_out_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_warp(rsp_warp), .rsp_data(rsp_data),
        .inflight(inflight), .tag_err(tag_err)
    );

    typedef struct {
        logic [7:0]  warp;
        logic [3:0]  op;
        logic [31:0] imm;
        int          due;
    } op_t;

    typedef struct {
        logic [7:0]  warp;
        logic [31:0] data;
    } res_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Requester side: pending command per requester.
    bit          rv [NREQ];
    logic [7:0]  rw [NREQ];
    logic [3:0]  ro [NREQ];
    logic [31:0] ri [NREQ];

    // Reference model state.
    int          m_rr;
    int          m_infl;
    bit          m_iv;
    logic [7:0]  m_w;
    logic [3:0]  m_o;
    logic [31:0] m_i;
    bit          m_err;
    int          m_tags[$];
    op_t         dpq[$];
    res_t        sb[NREQ][$];
    int          cyc = 0;
    int          seq = 0;

    // Stimulus knobs.
    int p_req = 0, p_inr = 0, p_rsr = 0;
    bit dp_stall = 1'b0, force_ov = 1'b0, want_rst = 1'b1;

    task automatic model_reset();
        m_rr   = NREQ - 1;
        m_infl = 0;
        m_iv   = 1'b0;
        m_w    = '0;
        m_o    = '0;
        m_i    = '0;
        m_err  = 1'b0;
        m_tags.delete();
        dpq.delete();
        for (int r = 0; r < NREQ; r++) sb[r].delete();
    endtask

    task automatic step();
        bit              can, ne, e_ordy, grant, hs_in, ret;
        int              g, head, j;
        logic [NREQ-1:0] e_rdy, e_rsp;
        res_t            exp_res;

        @(negedge clk);
        rst = want_rst;
        for (int i = 0; i < NREQ; i++) begin
            if (!rv[i] && $urandom_range(99) < p_req) begin
                rv[i] = 1'b1;
                rw[i] = {i[3:0], seq[3:0]};
                ro[i] = 4'($urandom);
                ri[i] = $urandom;
                seq++;
            end
            req_valid[i]         = rv[i];
            req_warp[i*8 +: 8]   = rw[i];
            req_op[i*4 +: 4]     = ro[i];
            req_imm[i*32 +: 32]  = ri[i];
            rsp_ready[i]         = ($urandom_range(99) < p_rsr);
        end
        dp_in_ready = ($urandom_range(99) < p_inr);
        if (force_ov) begin
            dp_out_valid = 1'b1;
            dp_out_warp  = 8'hEE;
            dp_out_data  = 32'hDEAD_BEEF;
        end else if (!dp_stall && dpq.size() > 0 && dpq[0].due <= cyc) begin
            dp_out_valid = 1'b1;
            dp_out_warp  = dpq[0].warp;
            dp_out_data  = dpq[0].imm + 32'(dpq[0].op);
        end else begin
            dp_out_valid = 1'b0;
        end

        #1;
        can = (!m_iv || dp_in_ready) && (m_infl < MAXI);
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            j = (m_rr + k) % NREQ;
            if (g < 0 && rv[j]) g = j;
        end
        e_rdy = '0;
        if (!rst && g >= 0 && can) e_rdy[g] = 1'b1;
        ne   = (m_tags.size() > 0);
        head = ne ? m_tags[0] : 0;
        e_rsp = '0;
        if (!rst && dp_out_valid && ne) e_rsp[head] = 1'b1;
        e_ordy = !rst && ne && rsp_ready[head];

        chk_eq("req_ready", req_ready, e_rdy);
        chk_eq("rsp_valid", rsp_valid, e_rsp);
        chk_eq("dp_out_ready", dp_out_ready, e_ordy);
        chk_eq("dp_in_valid", dp_in_valid, m_iv);
        chk_eq("inflight", inflight, m_infl);
        chk_eq("tag_err", tag_err, m_err);
        if (m_iv || rst) begin
            chk_eq("dp_warp", dp_warp, m_w);
            chk_eq("dp_op", dp_op, m_o);
            chk_eq("dp_imm", dp_imm, m_i);
        end
        if (dp_out_valid && e_ordy) begin
            if (sb[head].size() > 0) begin
                exp_res = sb[head][0];
                chk_eq("rsp_warp", rsp_warp, exp_res.warp);
                chk_eq("rsp_data", rsp_data, exp_res.data);
            end else begin
                chk_eq("scoreboard_empty", 1, 0);
            end
        end

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            grant = (e_rdy != '0);
            hs_in = m_iv && dp_in_ready;
            ret   = dp_out_valid && e_ordy;
            if (dp_out_valid && !ne) m_err = 1'b1;
            if (ret) begin
                if (sb[head].size() > 0) void'(sb[head].pop_front());
                if (dpq.size() > 0) void'(dpq.pop_front());
                void'(m_tags.pop_front());
                m_infl--;
            end
            if (hs_in) dpq.push_back('{m_w, m_o, m_i, cyc + LAT});
            if (grant) begin
                m_iv = 1'b1;
                m_w  = rw[g];
                m_o  = ro[g];
                m_i  = ri[g];
                m_tags.push_back(g);
                sb[g].push_back('{rw[g], ri[g] + 32'(ro[g])});
                m_rr = g;
                rv[g] = 1'b0;
                m_infl++;
            end else if (hs_in) begin
                m_iv = 1'b0;
            end
        end
        cyc++;
    endtask

    initial begin
        int n;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0; rw[i] = '0; ro[i] = '0; ri[i] = '0;
        end
        model_reset();

        want_rst = 1'b1;
        repeat (3) step();

        want_rst = 1'b0;
        p_req = 40; p_inr = 70; p_rsr = 70;
        repeat (1500) step();

        // Results stalled with every requester pending: credits must cap at MAXI.
        dp_stall = 1'b1; p_req = 100; p_inr = 100; p_rsr = 100;
        repeat (8) step();
        #2;
        chk_eq("credit_full", inflight, MAXI);
        chk_eq("credit_block", req_ready, 0);
        dp_stall = 1'b0;
        repeat (40) step();

        // Drain everything.
        p_req = 0;
        n = 0;
        while ((m_infl != 0 || m_iv || dpq.size() != 0) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk_eq("drain_timeout", 0, 1);

        // Result with nothing in flight.
        force_ov = 1'b1;
        repeat (2) step();
        force_ov = 1'b0;
        step();
        #2;
        chk_eq("tag_err_sticky", tag_err, 1);

        // Reset with three ops in flight.
        dp_stall = 1'b1; p_req = 100; p_inr = 100;
        repeat (3) step();
        #2;
        chk_eq("pre_rst_inflight", inflight, 3);
        want_rst = 1'b1;
        step();
        #2;
        chk_eq("rst_inflight", inflight, 0);
        chk_eq("rst_dp_in_valid", dp_in_valid, 0);
        chk_eq("rst_tag_err", tag_err, 0);
        chk_eq("rst_req_ready", req_ready, 0);
        want_rst = 1'b0;
        dp_stall = 1'b0;
        p_req = 50; p_inr = 80; p_rsr = 60;
        repeat (300) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
